// File: rtl/dram_burst_pkg.sv
// dram_burst_pkg: shared slot-entry type, command kind and wrap-safe cycle difference
package dram_burst_pkg;

    localparam int SLOT_DATA_W     = 64;
    localparam int SLOT_BURST_LEN  = 8;
    localparam int SLOT_PADDR_BITS = 19;
    localparam int SLOT_LANE_BITS  = $clog2(SLOT_BURST_LEN);

    typedef enum logic {
        CMD_READ  = 1'b0,
        CMD_WRITE = 1'b1
    } cmd_kind_e;

    typedef struct packed {
        cmd_kind_e                               kind;
        logic                                    chop;
        logic [31:0]                             start;
        logic [SLOT_LANE_BITS-1:0]               lane;
        logic [SLOT_PADDR_BITS-1:0]              paddr;
        logic [SLOT_BURST_LEN*SLOT_DATA_W-1:0]   wdata;
    } slot_t;

    function automatic logic signed [31:0] cyc_diff(input logic [31:0] a, input logic [31:0] b);
        return signed'(a - b);
    endfunction

endpackage

// File: rtl/burst_slot_fifo.sv
// burst_slot_fifo: power-of-two circular FIFO with simultaneous push and pop
module burst_slot_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic         clk_in,
    input  logic         rst_N_in,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wp, rp;

    assign dout  = mem[rp[AW-1:0]];
    assign empty = wp == rp;
    assign full  = (wp ^ rp) == {1'b1, {AW{1'b0}}};

    // read and write pointers; the extra MSB distinguishes full from empty
    always_ff @(posedge clk_in or negedge rst_N_in) begin
        if (!rst_N_in) begin
            wp <= '0;
            rp <= '0;
        end else begin
            if (push) wp <= wp + 1'b1;
            if (pop)  rp <= rp + 1'b1;
        end
    end

    // entry storage needs no reset: it is only observed when not empty
    always_ff @(posedge clk_in) begin
        if (push) mem[wp[AW-1:0]] <= din;
    end

endmodule

// File: rtl/dram_burst_engine.sv
// dram_burst_engine: schedules READ/WRITE data bursts on DQ at CAS/write latency
// Optional burst chop (BURST_LEN/2 beats) enabled by defining DRAM_BURST_CHOP_EN.
// The slot-entry struct takes DATA_W/BURST_LEN/PADDR_BITS widths from dram_burst_pkg.
module dram_burst_engine #(
    parameter int DATA_W          = dram_burst_pkg::SLOT_DATA_W,
    parameter int BURST_LEN       = dram_burst_pkg::SLOT_BURST_LEN,
    parameter int CAS_LATENCY     = 22,
    parameter int WRITE_LATENCY   = 16,
    parameter int MAX_OUTSTANDING = 32,
    parameter int PADDR_BITS      = dram_burst_pkg::SLOT_PADDR_BITS,
    parameter int COL_BITS        = 4
) (
    input  logic                          clk_in,
    input  logic                          rst_N_in,
    input  logic                          cmd_valid_in,
    output logic                          cmd_ready_out,
    input  logic                          cmd_write_in,
`ifdef DRAM_BURST_CHOP_EN
    input  logic                          cmd_chop_in,
`endif
    input  logic [PADDR_BITS-1:0]         cmd_paddr_in,
    input  logic [COL_BITS-1:0]           cmd_col_in,
    input  logic [BURST_LEN*DATA_W-1:0]   wdata_in,
    input  logic [DATA_W-1:0]             dq_in,
    output logic [DATA_W-1:0]             dq_out,
    output logic                          dq_oe_out,
    output logic                          rd_valid_out,
    output logic [BURST_LEN*DATA_W-1:0]   rd_data_out,
    output logic [PADDR_BITS-1:0]         rd_paddr_out,
    output logic                          bus_busy_out
);

    import dram_burst_pkg::*;

    localparam int          LB       = $clog2(BURST_LEN);
    localparam logic [31:0] FULL_LEN = 32'(BURST_LEN);
    localparam logic [31:0] HALF_LEN = 32'(BURST_LEN / 2);

    logic [31:0]                 now, next_free, slot_s, beat, head_len;
    slot_t                       push_e, head;
    logic                        full, empty, accept, active, last, chop, head_rd;
    logic [LB-1:0]               lidx;
    logic [BURST_LEN*DATA_W-1:0] rline, line_nxt;

`ifdef DRAM_BURST_CHOP_EN
    assign chop = cmd_chop_in;
`else
    assign chop = 1'b0;
`endif

    // slot booking, head-of-queue beat tracking and DQ drive
    always_comb begin
        slot_s        = now + (cmd_write_in ? 32'(WRITE_LATENCY) : 32'(CAS_LATENCY));
        cmd_ready_out = !full && cyc_diff(slot_s, next_free) >= 0;
        accept        = cmd_valid_in && cmd_ready_out;
        push_e        = '{kind: cmd_kind_e'(cmd_write_in), chop: chop, start: slot_s,
                          lane: LB'(cmd_col_in), paddr: cmd_paddr_in, wdata: wdata_in};
        beat          = now - head.start;
        head_len      = head.chop ? HALF_LEN : FULL_LEN;
        active        = !empty && cyc_diff(now, head.start) >= 0 && beat < head_len;
        last          = active && beat == head_len - 1;
        head_rd       = head.kind == CMD_READ;
        lidx          = head.lane + LB'(beat);
        line_nxt      = beat == 0 ? '0 : rline;
        line_nxt[lidx*DATA_W +: DATA_W] = dq_in;
        bus_busy_out  = active;
        dq_oe_out     = active && !head_rd;
        dq_out        = dq_oe_out ? head.wdata[lidx*DATA_W +: DATA_W] : '0;
    end

    // cycle counter, next free slot, read-line assembly and read return
    always_ff @(posedge clk_in or negedge rst_N_in) begin
        if (!rst_N_in) begin
            now          <= '0;
            next_free    <= '0;
            rline        <= '0;
            rd_valid_out <= 1'b0;
            rd_data_out  <= '0;
            rd_paddr_out <= '0;
        end else begin
            now          <= now + 1'b1;
            if (accept) next_free <= slot_s + (chop ? HALF_LEN : FULL_LEN);
            rd_valid_out <= last && head_rd;
            if (active && head_rd) rline <= line_nxt;
            if (last && head_rd) begin
                rd_data_out  <= line_nxt;
                rd_paddr_out <= head.paddr;
            end
        end
    end

    burst_slot_fifo #(.W($bits(slot_t)), .DEPTH(MAX_OUTSTANDING)) u_fifo (
        .clk_in   (clk_in),
        .rst_N_in (rst_N_in),
        .push     (accept),
        .din      (push_e),
        .pop      (last),
        .dout     (head),
        .full     (full),
        .empty    (empty)
    );

endmodule

// File: tb/tb_dram_burst_engine.sv
// tb_dram_burst_engine: directed table-driven checks of burst timing, ordering and slot refusal
module tb_dram_burst_engine;

    localparam int DW = 64;
    localparam int BL = 8;
    localparam int LW = DW * BL;

    logic          clk_in = 1'b0;
    logic          rst_N_in = 1'b0;
    logic          cmd_valid_in = 1'b0;
    logic          cmd_write_in = 1'b0;
    logic          cmd_chop_in = 1'b0;
    logic [18:0]   cmd_paddr_in = '0;
    logic [3:0]    cmd_col_in = '0;
    logic [LW-1:0] wdata_in = '0;
    logic [DW-1:0] dq_in = '0;

    logic          a_ready, a_oe, a_rv, a_busy, b_ready, b_oe, b_rv, b_busy;
    logic [DW-1:0] a_dq, b_dq;
    logic [LW-1:0] a_rd, b_rd;
    logic [18:0]   a_rp, b_rp;

    dram_burst_engine u_a (
        .clk_in(clk_in), .rst_N_in(rst_N_in), .cmd_valid_in(cmd_valid_in), .cmd_ready_out(a_ready),
        .cmd_write_in(cmd_write_in),
`ifdef DRAM_BURST_CHOP_EN
        .cmd_chop_in(cmd_chop_in),
`endif
        .cmd_paddr_in(cmd_paddr_in), .cmd_col_in(cmd_col_in), .wdata_in(wdata_in), .dq_in(dq_in),
        .dq_out(a_dq), .dq_oe_out(a_oe), .rd_valid_out(a_rv), .rd_data_out(a_rd),
        .rd_paddr_out(a_rp), .bus_busy_out(a_busy)
    );

    dram_burst_engine #(.MAX_OUTSTANDING(2)) u_b (
        .clk_in(clk_in), .rst_N_in(rst_N_in), .cmd_valid_in(cmd_valid_in), .cmd_ready_out(b_ready),
        .cmd_write_in(cmd_write_in),
`ifdef DRAM_BURST_CHOP_EN
        .cmd_chop_in(cmd_chop_in),
`endif
        .cmd_paddr_in(cmd_paddr_in), .cmd_col_in(cmd_col_in), .wdata_in(wdata_in), .dq_in(dq_in),
        .dq_out(b_dq), .dq_oe_out(b_oe), .rd_valid_out(b_rv), .rd_data_out(b_rd),
        .rd_paddr_out(b_rp), .bus_busy_out(b_busy)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        int          c;
        logic        oe;
        logic [63:0] dq;
    } wvec_t;

    typedef struct {
        int   c;
        logic busy;
        logic oe;
    } svec_t;

    int    total = 0;
    int    bad = 0;
    int    cyc = 0;
    wvec_t wt[18];
    svec_t st[18];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk_in);
        #1;
        cyc++;
    endtask

    task automatic goto(input int c);
        while (cyc < c) tick();
    endtask

    task automatic do_reset;
        rst_N_in = 1'b0;
        cmd_valid_in = 1'b0;
        cmd_write_in = 1'b0;
        cmd_chop_in = 1'b0;
        cmd_col_in = '0;
        dq_in = '0;
        repeat (3) @(posedge clk_in);
        #1;
        rst_N_in = 1'b1;
        cyc = 0;
    endtask

    initial begin
        for (int i = 0; i < 18; i++) begin
            wt[i].c  = 20 + i;
            wt[i].oe = (wt[i].c >= 21) && (wt[i].c <= 36);
            wt[i].dq = !wt[i].oe ? 64'h0 :
                       (wt[i].c <= 28) ? 64'(32'hA0 + wt[i].c - 21) :
                       64'(32'hB0 + ((5 + wt[i].c - 29) % 8));
            st[i].c    = 21 + i;
            st[i].busy = (st[i].c >= 22) && (st[i].c <= 37);
            st[i].oe   = (st[i].c >= 30) && (st[i].c <= 37);
        end

        // reset state
        do_reset();
        #1;
        chk("rst_ready", 64'(a_ready), 64'd1);
        chk("rst_oe", 64'(a_oe), 64'd0);
        chk("rst_busy", 64'(a_busy), 64'd0);
        chk("rst_dq", a_dq, 64'd0);
        chk("rst_rv", 64'(a_rv), 64'd0);
        chk("rst_rdata", a_rd[63:0], 64'd0);
        chk("rst_rpaddr", 64'(a_rp), 64'd0);

        // read at T=10, col 3
        goto(10);
        cmd_valid_in = 1'b1; cmd_write_in = 1'b0; cmd_col_in = 4'd3; cmd_paddr_in = 19'h1234;
        #1;
        chk("rd_ready", 64'(a_ready), 64'd1);
        tick();
        cmd_valid_in = 1'b0;
        goto(31);
        chk("rd_busy_pre", 64'(a_busy), 64'd0);
        for (int i = 0; i < 8; i++) begin
            tick();
            dq_in = 64'h100 + 64'(i);
            chk("rd_busy", 64'(a_busy), 64'd1);
            chk("rd_oe", 64'(a_oe), 64'd0);
            chk("rd_rv_early", 64'(a_rv), 64'd0);
        end
        tick();
        chk("rd_rv", 64'(a_rv), 64'd1);
        chk("rd_busy_post", 64'(a_busy), 64'd0);
        chk("rd_paddr", 64'(a_rp), 64'h1234);
        for (int l = 0; l < 8; l++) chk("rd_lane", a_rd[l*DW +: DW], 64'h100 + 64'((l + 5) % 8));
        tick();
        chk("rd_rv_pulse", 64'(a_rv), 64'd0);
        chk("rd_hold", a_rd[3*DW +: DW], 64'h100);

        // write at T=5 col 0, then back-to-back wrapped write at T=13 col 5
        do_reset();
        for (int k = 0; k < 8; k++) wdata_in[k*DW +: DW] = 64'hA0 + 64'(k);
        goto(5);
        cmd_valid_in = 1'b1; cmd_write_in = 1'b1; cmd_col_in = 4'd0;
        tick();
        cmd_valid_in = 1'b0;
        for (int k = 0; k < 8; k++) wdata_in[k*DW +: DW] = 64'hB0 + 64'(k);
        goto(12);
        cmd_col_in = 4'd5;
        #1;
        chk("wr_collide_ready", 64'(a_ready), 64'd0);
        tick();
        cmd_valid_in = 1'b1;
        #1;
        chk("wr_b2b_ready", 64'(a_ready), 64'd1);
        tick();
        cmd_valid_in = 1'b0;
        wdata_in = '0;
        for (int i = 0; i < 18; i++) begin
            goto(wt[i].c);
            chk("wr_oe", 64'(a_oe), 64'(wt[i].oe));
            chk("wr_busy", 64'(a_busy), 64'(wt[i].oe));
            chk("wr_dq", a_dq, wt[i].dq);
        end

        // read at T=0, write requested from T=1 must wait for a free slot
        do_reset();
        cmd_valid_in = 1'b1; cmd_write_in = 1'b0; cmd_col_in = 4'd0;
        tick();
        cmd_write_in = 1'b1;
        while (1) begin
            #1;
            chk("slot_ready", 64'(a_ready), 64'(cyc >= 14));
            if (a_ready || cyc >= 20) break;
            tick();
        end
        tick();
        cmd_valid_in = 1'b0;
        for (int i = 0; i < 18; i++) begin
            goto(st[i].c);
            chk("slot_busy", 64'(a_busy), 64'(st[i].busy));
            chk("slot_oe", 64'(a_oe), 64'(st[i].oe));
            if (st[i].c == 30) chk("slot_rv", 64'(a_rv), 64'd1);
        end

        // depth-2 instance: full FIFO refuses, then reset mid-burst
        do_reset();
        cmd_valid_in = 1'b1; cmd_write_in = 1'b0;
        tick();
        cmd_valid_in = 1'b0;
        goto(8);
        cmd_valid_in = 1'b1;
        #1;
        chk("full_second_ready", 64'(b_ready), 64'd1);
        tick();
        while (1) begin
            #1;
            chk("full_ready", 64'(b_ready), 64'(cyc >= 30));
            if (b_ready || cyc >= 40) break;
            tick();
        end
        tick();
        cmd_valid_in = 1'b0;
        goto(33);
        chk("mid_busy", 64'(b_busy), 64'd1);
        rst_N_in = 1'b0;
        #1;
        chk("async_busy", 64'(b_busy), 64'd0);
        chk("async_oe", 64'(b_oe), 64'd0);
        #1;
        rst_N_in = 1'b1;
        cyc = 0;
        begin
            logic seen;
            seen = 1'b0;
            repeat (60) begin
                tick();
                seen = seen | b_rv | b_busy;
            end
            chk("no_rv_after_rst", 64'(seen), 64'd0);
        end

`ifdef DRAM_BURST_CHOP_EN
        // chopped read at T=0 col 6, next slot free from cycle 26
        do_reset();
        cmd_valid_in = 1'b1; cmd_write_in = 1'b0; cmd_chop_in = 1'b1; cmd_col_in = 4'd6;
        cmd_paddr_in = 19'h0ABC;
        tick();
        cmd_valid_in = 1'b0; cmd_chop_in = 1'b0; cmd_col_in = 4'd0;
        goto(3);
        #1;
        chk("chop_ready_early", 64'(a_ready), 64'd0);
        tick();
        cmd_valid_in = 1'b1;
        #1;
        chk("chop_ready_slot", 64'(a_ready), 64'd1);
        tick();
        cmd_valid_in = 1'b0;
        goto(21);
        for (int i = 0; i < 4; i++) begin
            tick();
            dq_in = 64'h200 + 64'(i);
            chk("chop_busy", 64'(a_busy), 64'd1);
        end
        tick();
        dq_in = 64'hFFFF;
        chk("chop_rv", 64'(a_rv), 64'd1);
        chk("chop_next_busy", 64'(a_busy), 64'd1);
        chk("chop_paddr", 64'(a_rp), 64'h0ABC);
        for (int l = 0; l < 8; l++)
            chk("chop_lane", a_rd[l*DW +: DW],
                (l == 6) ? 64'h200 : (l == 7) ? 64'h201 : (l == 0) ? 64'h202 : (l == 1) ? 64'h203 : 64'h0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
